// File: rtl/output_buffer_logic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : RouterPkg
//  Description : Shared types and constants for the node output buffer:
//                packet type, bytes per packet and serializer FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package RouterPkg;

    // Whole packet as seen by the router core; element 3 goes out first.
    typedef logic [3:0][7:0] pkt_t;

    localparam int BYTES_PER_PKT = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } obuf_state_t;

endpackage
`default_nettype wire

// File: rtl/output_buffer_logic_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_fifo
//  Description : Small packet FIFO. The head entry is presented directly
//                from storage on rd_data; rd_en pops it. Writes while full
//                are ignored, even when a pop happens on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo
    import RouterPkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic wr_en,
    input  pkt_t wr_data,
    input  logic rd_en,
    output pkt_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    pkt_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en & ~full;
    assign w_pop   = rd_en & ~empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_buffer_logic.sv
`default_nettype none
// ============================================================================
//  Module      : output_buffer_logic
//  Description : Transmit-side node buffer. Queues 32-bit packets from the
//                router and serializes each one MSB byte first over four
//                consecutive strobed cycles, with at least one idle cycle
//                between packets.
//                Optional macro OUTBUF_STATS_EN adds pkts_sent (wrapping)
//                and pkts_dropped (saturating) counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_buffer_logic
    import RouterPkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  pkt_t        packet_in,
    input  logic        packet_valid,
    output logic        buffer_full,
    input  logic        node_free,
    output logic        put_outbound,
    output logic [7:0]  payload_outbound,
    output logic        sending
`ifdef OUTBUF_STATS_EN
    ,
    output logic [15:0] pkts_sent,
    output logic [15:0] pkts_dropped
`endif
);

    localparam int                    BYTE_IDX_W = $clog2(BYTES_PER_PKT);
    localparam logic [BYTE_IDX_W-1:0] IDX_FIRST  = BYTE_IDX_W'(BYTES_PER_PKT - 1);

    obuf_state_t            r_state;
    logic [BYTE_IDX_W-1:0]  r_byte_idx;
    logic                   r_put;
    logic [7:0]             r_payload;
    pkt_t                   w_head;
    logic                   w_fifo_empty;
    logic                   w_pop;

    // The index wraps from 0 back to IDX_FIRST once head[0] is on the wire,
    // so SEND with IDX_FIRST marks the edge that closes the packet.
    assign w_pop = (r_state == SEND) && (r_byte_idx == IDX_FIRST);

    pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_pkt_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (packet_valid),
        .wr_data (packet_in),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (buffer_full),
        .empty   (w_fifo_empty)
    );

    // Serializer FSM: launch on a queued packet when the node is free, then
    // walk the byte index down and pop the head once the last byte is sent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_byte_idx <= IDX_FIRST;
            r_put      <= 1'b0;
            r_payload  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty && node_free) begin
                        r_state    <= SEND;
                        r_put      <= 1'b1;
                        r_payload  <= w_head[IDX_FIRST];
                        r_byte_idx <= IDX_FIRST - 1'b1;
                    end
                end
                SEND: begin
                    if (w_pop) begin
                        r_state    <= IDLE;
                        r_put      <= 1'b0;
                        r_payload  <= 8'h00;
                        r_byte_idx <= IDX_FIRST;
                    end else begin
                        r_payload  <= w_head[r_byte_idx];
                        r_byte_idx <= r_byte_idx - 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_put      <= 1'b0;
                    r_payload  <= 8'h00;
                    r_byte_idx <= IDX_FIRST;
                end
            endcase
        end
    end

    assign put_outbound     = r_put;
    assign payload_outbound = r_payload;
    assign sending          = (r_state == SEND);

`ifdef OUTBUF_STATS_EN
    logic [15:0] r_pkts_sent;
    logic [15:0] r_pkts_dropped;

    // Sent count wraps; drop count sticks at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pkts_sent    <= 16'h0000;
            r_pkts_dropped <= 16'h0000;
        end else begin
            if (w_pop) begin
                r_pkts_sent <= r_pkts_sent + 16'h0001;
            end
            if (packet_valid && buffer_full && (r_pkts_dropped != 16'hFFFF)) begin
                r_pkts_dropped <= r_pkts_dropped + 16'h0001;
            end
        end
    end

    assign pkts_sent    = r_pkts_sent;
    assign pkts_dropped = r_pkts_dropped;
`endif

endmodule
`default_nettype wire
